hilo_div_ctrl: RTL and testbench



---
 rtl/hilo_div_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// HI/LO register owner and serial-divider front end for the EX stage.
// Executes MTHI/MTLO/MFHI/MFLO, issues DIV/DIVU, and stalls HI/LO users while a divide is in flight.
module hilo_div_ctrl #(
  parameter int DIV_TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] hilo_rdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_by_zero_o,
  output logic        timeout_o,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  input  logic [31:0] div_quotient_i,
  input  logic [31:0] div_remainder_i,
  input  logic        div_finish_i
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;
  localparam logic [2:0] OP_MFHI = 3'b101;
  localparam logic [2:0] OP_MFLO = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [31:0]   hi_r, hi_s, lo_r, lo_s;
  logic [31:0]   dividend_r, dividend_s, divisor_r, divisor_s;
  logic          signed_r, signed_s;
  logic          start_r;
  logic          dbz_r, dbz_s, to_r, to_s;
  logic          stall_s, accept_s;
  logic [31:0]   rdata_s;

  // Every op code except the two "none" encodings touches HI/LO or the divider.
  function automatic logic is_hilo_op(input logic [2:0] op);
    return (op != 3'b000) && (op != 3'b111);
  endfunction

  // Interlock, accept qualification and the MFHI/MFLO read mux.
  always_comb begin
    stall_s  = op_valid_i & (state_r == BUSY) & is_hilo_op(op_i);
    accept_s = op_valid_i & ~stall_s & ~flush_i;
    case (op_i)
      OP_MFHI: rdata_s = hi_r;
      OP_MFLO: rdata_s = lo_r;
      default: rdata_s = 32'd0;
    endcase
  end

  // Next-state and register-update decisions.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    hi_s       = hi_r;
    lo_s       = lo_r;
    dividend_s = dividend_r;
    divisor_s  = divisor_r;
    signed_s   = signed_r;
    dbz_s      = 1'b0;
    to_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (op_i)
            OP_DIV, OP_DIVU: begin
              // A zero divisor never gets a finish from the divider, so it is never started.
              if (rt_data_i != 32'd0) begin
                dividend_s = rs_data_i;
                divisor_s  = rt_data_i;
                signed_s   = (op_i == OP_DIV);
                cnt_s      = '0;
                state_s    = BUSY;
              end else begin
                dbz_s = 1'b1;
              end
            end
            OP_MTHI: hi_s = rs_data_i;
            OP_MTLO: lo_s = rs_data_i;
            default: begin
              state_s = IDLE;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // Flush takes priority over a finish arriving in the same cycle.
        if (flush_i) begin
          state_s = IDLE;
        end else if (div_finish_i) begin
          lo_s    = div_quotient_i;
          hi_s    = div_remainder_i;
          state_s = IDLE;
        end else if (cnt_r == CW'(DIV_TIMEOUT)) begin
          to_s    = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, architectural HI/LO, divider interface and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      dividend_r <= 32'd0;
      divisor_r  <= 32'd0;
      signed_r   <= 1'b0;
      start_r    <= 1'b0;
      dbz_r      <= 1'b0;
      to_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      hi_r       <= hi_s;
      lo_r       <= lo_s;
      dividend_r <= dividend_s;
      divisor_r  <= divisor_s;
      signed_r   <= signed_s;
      start_r    <= (state_s == BUSY);
      dbz_r      <= dbz_s;
      to_r       <= to_s;
    end
  end

  assign stall_o        = stall_s;
  assign hilo_rdata_o   = rdata_s;
  assign hi_o           = hi_r;
  assign lo_o           = lo_r;
  assign div_by_zero_o  = dbz_r;
  assign timeout_o      = to_r;
  assign div_start_o    = start_r;
  assign div_signed_o   = signed_r;
  assign div_dividend_o = dividend_r;
  assign div_divisor_o  = divisor_r;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl with a 34-cycle serial divider model.
module tb_hilo_div_ctrl;

  localparam int DIV_TIMEOUT = 63;
  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;
  localparam logic [2:0] OP_MFHI = 3'b101;
  localparam logic [2:0] OP_MFLO = 3'b110;

  logic        clk, rst, op_valid_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] rs_data_i, rt_data_i;
  logic        stall_o, div_by_zero_o, timeout_o, div_start_o, div_signed_o, div_finish_i;
  logic [31:0] hilo_rdata_o, hi_o, lo_o, div_dividend_o, div_divisor_o;
  logic [31:0] div_quotient_i, div_remainder_i;

  int errors = 0;
  int checks = 0;
  logic model_en = 1'b1;
  int unsigned mcnt;

  hilo_div_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .flush_i(flush_i),
    .stall_o(stall_o), .hilo_rdata_o(hilo_rdata_o), .hi_o(hi_o), .lo_o(lo_o),
    .div_by_zero_o(div_by_zero_o), .timeout_o(timeout_o),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
    .div_finish_i(div_finish_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: finish in the 34th cycle that start is held high.
  always @(posedge clk) begin
    if (rst || !div_start_o) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end
  assign div_finish_i = div_start_o && model_en && (mcnt == 33);

  always_comb begin
    div_quotient_i  = 32'd0;
    div_remainder_i = 32'd0;
    if (div_divisor_o != 32'd0) begin
      if (div_signed_o) begin
        div_quotient_i  = $signed(div_dividend_o) / $signed(div_divisor_o);
        div_remainder_i = $signed(div_dividend_o) % $signed(div_divisor_o);
      end else begin
        div_quotient_i  = div_dividend_o / div_divisor_o;
        div_remainder_i = div_dividend_o % div_divisor_o;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] data);
    op_valid_i = 1'b1; op_i = op; rs_data_i = data;
    step();
    op_valid_i = 1'b0; op_i = OP_NONE;
  endtask

  // Issue a divide in the current cycle; n = cycle index (accept = 0) where start is first seen low.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, output int n);
    op_valid_i = 1'b1; op_i = sgn ? OP_DIV : OP_DIVU; rs_data_i = a; rt_data_i = b;
    step();
    op_valid_i = 1'b0; op_i = OP_NONE;
    n = 1;
    while (div_start_o === 1'b1 && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid_i = 1'b0; op_i = OP_NONE; flush_i = 1'b0;
    rs_data_i = 32'd0; rt_data_i = 32'd0;
    step(); step();
    checks++; if ({hi_o, lo_o} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", hi_o, lo_o); end
    checks++; if ({div_dividend_o, div_divisor_o} !== 64'd0) begin errors++; $display("FAIL reset_operands: got %h/%h expected 0/0", div_dividend_o, div_divisor_o); end
    checks++; if ({div_start_o, div_signed_o, div_by_zero_o, timeout_o, stall_o} !== 5'd0) begin errors++;
      $display("FAIL reset_flags: got %b expected 00000", {div_start_o, div_signed_o, div_by_zero_o, timeout_o, stall_o}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_mt_mf();
    do_op(OP_MTHI, 32'hDEADBEEF);
    do_op(OP_MTLO, 32'h12345678);
    op_valid_i = 1'b1; op_i = OP_MFHI; #1;
    checks++; if (hilo_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL mfhi: got %h expected deadbeef", hilo_rdata_o); end
    op_i = OP_MFLO; #1;
    checks++; if (hilo_rdata_o !== 32'h12345678) begin errors++; $display("FAIL mflo: got %h expected 12345678", hilo_rdata_o); end
    op_i = OP_NONE; #1;
    checks++; if (hilo_rdata_o !== 32'd0) begin errors++; $display("FAIL rdata_none: got %h expected 0", hilo_rdata_o); end
    op_valid_i = 1'b0;
    step();
  endtask

  task automatic test_divu_latency();
    op_valid_i = 1'b1; op_i = OP_DIVU; rs_data_i = 32'd100; rt_data_i = 32'd7; #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL div_no_stall: got %b expected 0", stall_o); end
    step();
    op_i = OP_MFLO; #1;
    checks++; if ({div_signed_o, div_dividend_o, div_divisor_o} !== {1'b0, 32'd100, 32'd7}) begin errors++;
      $display("FAIL divu_operands: got %b %h %h expected 0 64 7", div_signed_o, div_dividend_o, div_divisor_o); end
    for (int c = 1; c <= 34; c++) begin
      checks++; if ({div_start_o, stall_o} !== 2'b11) begin errors++; $display("FAIL busy_c%0d: got start/stall %b expected 11", c, {div_start_o, stall_o}); end
      step();
    end
    checks++; if ({div_start_o, stall_o} !== 2'b00) begin errors++; $display("FAIL c35_flags: got start/stall %b expected 00", {div_start_o, stall_o}); end
    checks++; if ({lo_o, hi_o, hilo_rdata_o} !== {32'd14, 32'd2, 32'd14}) begin errors++;
      $display("FAIL divu_result: got lo=%0d hi=%0d rd=%0d expected 14 2 14", lo_o, hi_o, hilo_rdata_o); end
    op_valid_i = 1'b0; op_i = OP_NONE;
    step();
  endtask

  task automatic test_div_signed();
    int n;
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, n);
    checks++; if (n !== 35) begin errors++; $display("FAIL sdiv1_latency: got %0d expected 35", n); end
    checks++; if ({lo_o, hi_o} !== {32'hFFFFFFFD, 32'hFFFFFFFF}) begin errors++; $display("FAIL sdiv1: got lo=%h hi=%h expected fffffffd ffffffff", lo_o, hi_o); end
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, n);
    checks++; if ({lo_o, hi_o} !== {32'hFFFFFFFD, 32'd1}) begin errors++; $display("FAIL sdiv2: got lo=%h hi=%h expected fffffffd 00000001", lo_o, hi_o); end
  endtask

  task automatic test_div_by_zero();
    do_op(OP_MTHI, 32'h11);
    do_op(OP_MTLO, 32'h22);
    op_valid_i = 1'b1; op_i = OP_DIV; rs_data_i = 32'd50; rt_data_i = 32'd0;
    step();
    op_i = OP_MFHI; #1;
    checks++; if ({div_by_zero_o, div_start_o, stall_o} !== 3'b100) begin errors++;
      $display("FAIL dbz_pulse: got dbz/start/stall %b expected 100", {div_by_zero_o, div_start_o, stall_o}); end
    checks++; if (hilo_rdata_o !== 32'h11) begin errors++; $display("FAIL dbz_mfhi: got %h expected 11", hilo_rdata_o); end
    step();
    op_valid_i = 1'b0; op_i = OP_NONE;
    checks++; if ({div_by_zero_o, div_start_o} !== 2'b00) begin errors++; $display("FAIL dbz_single: got dbz/start %b expected 00", {div_by_zero_o, div_start_o}); end
    checks++; if ({hi_o, lo_o} !== {32'h11, 32'h22}) begin errors++; $display("FAIL dbz_hilo: got %h/%h expected 11/22", hi_o, lo_o); end
  endtask

  task automatic test_flush();
    int n;
    op_valid_i = 1'b1; op_i = OP_DIVU; rs_data_i = 32'd100; rt_data_i = 32'd7;
    step();
    op_valid_i = 1'b0; op_i = OP_NONE;
    for (int c = 1; c < 10; c++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++; if (div_start_o !== 1'b0) begin errors++; $display("FAIL flush_start: got %b expected 0", div_start_o); end
    checks++; if ({hi_o, lo_o} !== {32'h11, 32'h22}) begin errors++; $display("FAIL flush_hilo: got %h/%h expected 11/22", hi_o, lo_o); end
    do_div(1'b0, 32'd9, 32'd4, n);
    checks++; if (n !== 35) begin errors++; $display("FAIL post_flush_latency: got %0d expected 35", n); end
    checks++; if ({lo_o, hi_o} !== {32'd2, 32'd1}) begin errors++; $display("FAIL post_flush_div: got lo=%0d hi=%0d expected 2 1", lo_o, hi_o); end
    // Flush landing on the finish cycle must discard the result.
    op_valid_i = 1'b1; op_i = OP_DIVU; rs_data_i = 32'd50; rt_data_i = 32'd5;
    step();
    op_valid_i = 1'b0; op_i = OP_NONE;
    for (int c = 1; c < 34; c++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++; if ({lo_o, hi_o, 1'b0, div_start_o} !== {32'd2, 32'd1, 2'b00}) begin errors++;
      $display("FAIL flush_beats_finish: got lo=%0d hi=%0d start=%b expected 2 1 0", lo_o, hi_o, div_start_o); end
    // Flush in IDLE drops the op.
    flush_i = 1'b1;
    do_op(OP_MTHI, 32'h55);
    flush_i = 1'b0;
    checks++; if (hi_o !== 32'd1) begin errors++; $display("FAIL idle_flush: got hi=%h expected 1", hi_o); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_div(1'b1, 32'd100, 32'd7, n);
    checks++; if ({lo_o, hi_o} !== {32'd14, 32'd2}) begin errors++; $display("FAIL b2b_first: got lo=%0d hi=%0d expected 14 2", lo_o, hi_o); end
    do_div(1'b0, 32'hFFFFFFFF, 32'd16, n);
    checks++; if (n !== 35) begin errors++; $display("FAIL b2b_latency: got %0d expected 35", n); end
    checks++; if ({lo_o, hi_o} !== {32'h0FFFFFFF, 32'd15}) begin errors++; $display("FAIL b2b_second: got lo=%h hi=%h expected 0fffffff f", lo_o, hi_o); end
  endtask

  task automatic test_reset_busy();
    op_valid_i = 1'b1; op_i = OP_DIV; rs_data_i = 32'd100; rt_data_i = 32'd7;
    step();
    op_valid_i = 1'b0; op_i = OP_NONE;
    for (int c = 1; c < 20; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({div_start_o, div_signed_o, div_by_zero_o, timeout_o} !== 4'd0) begin errors++;
      $display("FAIL rst_busy_flags: got %b expected 0000", {div_start_o, div_signed_o, div_by_zero_o, timeout_o}); end
    checks++; if ({hi_o, lo_o, div_dividend_o, div_divisor_o} !== 128'd0) begin errors++;
      $display("FAIL rst_busy_regs: got %h %h %h %h expected 0", hi_o, lo_o, div_dividend_o, div_divisor_o); end
    for (int c = 0; c < 20; c++) step();
    checks++; if ({hi_o, lo_o, 31'd0, div_start_o} !== 96'd0) begin errors++; $display("FAIL rst_discard: got hi=%h lo=%h start=%b expected 0", hi_o, lo_o, div_start_o); end
  endtask

  task automatic test_timeout();
    int n;
    do_op(OP_MTHI, 32'hAA);
    model_en = 1'b0;
    op_valid_i = 1'b1; op_i = OP_DIV; rs_data_i = 32'd5; rt_data_i = 32'd3;
    step();
    op_valid_i = 1'b0; op_i = OP_NONE;
    n = 1;
    while (timeout_o !== 1'b1 && n < 100) begin
      checks++; if (div_start_o !== 1'b1) begin errors++; $display("FAIL wd_early_stop: cycle %0d start=%b expected 1", n, div_start_o); end
      step();
      n++;
    end
    checks++; if (n < DIV_TIMEOUT || n > DIV_TIMEOUT + 2) begin errors++; $display("FAIL wd_cycle: got %0d expected %0d..%0d", n, DIV_TIMEOUT, DIV_TIMEOUT + 2); end
    checks++; if (div_start_o !== 1'b0) begin errors++; $display("FAIL wd_idle: got start=%b expected 0", div_start_o); end
    checks++; if ({hi_o, lo_o} !== {32'hAA, 32'd0}) begin errors++; $display("FAIL wd_hilo: got %h/%h expected aa/0", hi_o, lo_o); end
    step();
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL wd_pulse_width: got %b expected 0", timeout_o); end
    model_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mt_mf();
    test_divu_latency();
    test_div_signed();
    test_div_by_zero();
    test_flush();
    test_back_to_back();
    test_reset_busy();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
